reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//   Parametrised multi-read-port register file for the single-cycle datapath.
//   Holds 2**AW words of DW bits with entry 0 hardwired to zero.
//   Provides NR combinational read ports, one synchronous write port and a
//   sequential bulk-clear engine. It sits between decode (register selects)
//   and the ALU operand/writeback paths.
// PARAMETERS
//   DW    32  data width in bits
//   AW    5   select width; depth = 2**AW entries
//   NR    2   number of read ports (>=1)
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   wr_en     in   1      write strobe, sampled at rising clk
//   wr_sel    in   AW     write register index
//   wr_data   in   DW     write data
//   rd_sel    in   NR*AW  packed read indices; port k = [k*AW +: AW]
//   rd_data   out  NR*DW  packed read data;    port k = [k*DW +: DW]
//   clr_req   in   1      start bulk clear (single-cycle pulse or level)
//   clr_busy  out  1      clear engine active; writes blocked
//   clr_done  out  1      one-cycle pulse after the last entry is cleared
// BEHAVIOUR
//   - Reset: all entries = 0, FSM = IDLE, clr_busy = 0, clr_done = 0.
//     Reset takes effect asynchronously, including during a clear.
//   - Read: rd_data[k] = mem[rd_sel[k]] combinationally (zero-cycle latency).
//     A select of 0 always returns 0. Ports are independent, and any number
//     of ports may read the same index.
//   - Write: on a rising clk with wr_en=1, clr_busy=0 and wr_sel!=0,
//     mem[wr_sel] <= wr_data. Writes to index 0 are discarded.
//     The new value is visible on reads from the next cycle.
//   - Clear FSM, states IDLE and CLEAR, with counter cnt of AW bits:
//       IDLE  -> CLEAR  when clr_req=1; cnt <= 1.
//       CLEAR: each cycle mem[cnt] <= 0 and cnt <= cnt+1.
//              When cnt = 2**AW-1 (last entry), that entry is cleared and
//              the FSM goes to IDLE, with clr_done=1 for exactly that
//              following cycle.
//     - The clear takes 2**AW-1 cycles; clr_busy=1 in every CLEAR cycle.
//     - clr_req while in CLEAR is ignored; no restart occurs.
//     - wr_en while clr_busy=1 is dropped, not queued.
//     - clr_req and wr_en in the same IDLE cycle: the write is performed,
//       then the clear starts and erases it.
//     - During CLEAR, reads return current contents: entries below cnt are
//       already 0, entries at or above cnt still hold their old values.
//     - cnt wrap is impossible because the FSM exits at the last entry.
// CONFIGURATION
//   BYPASS_EN (define): write-through forwarding. If wr_en=1, clr_busy=0,
//     wr_sel!=0 and rd_sel[k]==wr_sel, then rd_data[k]=wr_data in the same
//     cycle. Forwarding is applied per port.
//   Without BYPASS_EN: reads return the stored value only; the new data
//     appears on the cycle after the write.
// TESTING
//   1 Reset, then read all 32 indices on both ports -> all 0x00000000.
//   2 Write 0xDEADBEEF to r5, next cycle rd_sel0=5, rd_sel1=0
//     -> rd_data0=0xDEADBEEF, rd_data1=0.
//   3 Write 0xFFFFFFFF to r0, then read r0 -> 0x00000000.
//   4 Same cycle: wr r7=0x12345678 with rd_sel0=7
//     -> BYPASS_EN: 0x12345678 that cycle; without: old value, new next cycle.
//   5 Fill r1..r31 with index*0x01010101, pulse clr_req
//     -> clr_busy high for 31 cycles, then clr_done 1 cycle; all reads 0;
//     a wr_en to r3 mid-clear is dropped.
//   6 Assert rst at clear cycle 10 -> immediately clr_busy=0, all entries 0,
//     FSM IDLE; a write after release succeeds.

Source files
------------

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with entry 0 tied to zero and a sequential bulk-clear engine
// Optional feature: define BYPASS_EN for same-cycle write-through forwarding to matching read ports.
module reg_file_mp #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int NR = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_sel,
   input  logic [DW-1:0]    wr_data,
   input  logic [NR*AW-1:0] rd_sel,
   output logic [NR*DW-1:0] rd_data,
   input  logic             clr_req,
   output logic             clr_busy,
   output logic             clr_done
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;
   logic [DW-1:0]   mem_q [0:DEPTH-1];
   logic [DW-1:0]   mem_d [0:DEPTH-1];
   logic            wr_ok;

   // A write only lands when the clear engine is idle and the target is not r0.
   assign wr_ok    = wr_en && (state_q == IDLE) && (wr_sel != '0);
   assign clr_busy = (state_q == CLEAR);
   assign clr_done = done_q;

   // Next-state logic: write port, clear FSM, and the hardwired zero entry.
   always_comb begin
      mem_d   = mem_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // A write and a clear request together: the write lands, then the clear wipes it.
            if (wr_ok) begin
               mem_d[wr_sel] = wr_data;
            end
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = AW'(1);
            end
         end
         CLEAR: begin
            mem_d[cnt_q] = '0;
            // Leave at the last entry so cnt never wraps back onto r0.
            if (cnt_q == '1) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      mem_d[0] = '0;
   end

   // State and storage registers; reset is asynchronous and aborts any clear in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Combinational read ports, each independent, with optional per-port forwarding.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NR; k++) begin
`ifdef BYPASS_EN
         if (wr_ok && (rd_sel[k*AW +: AW] == wr_sel)) begin
            rd_data[k*DW +: DW] = wr_data;
         end else begin
            rd_data[k*DW +: DW] = mem_q[rd_sel[k*AW +: AW]];
         end
`else
         rd_data[k*DW +: DW] = mem_q[rd_sel[k*AW +: AW]];
`endif
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed scoreboard bench for reg_file_mp
module tb_reg_file_mp;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_sel;
   logic [31:0] wr_data;
   logic [9:0]  rd_sel;
   logic [63:0] rd_data;
   logic        clr_req;
   logic        clr_busy;
   logic        clr_done;

   reg_file_mp #(.DW(32), .AW(5), .NR(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_data  (wr_data),
      .rd_sel   (rd_sel),
      .rd_data  (rd_data),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] ref_mem [0:31];
   int          checks = 0;
   int          errors = 0;

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check_val(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty observed=%h", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic read_pair(input logic [4:0] s0, input logic [4:0] s1, input string tag);
      rd_sel = {s1, s0};
      expect_val($sformatf("%s_rd0_r%0d", tag, s0), ref_mem[s0]);
      expect_val($sformatf("%s_rd1_r%0d", tag, s1), ref_mem[s1]);
      #1;
      check_val(rd_data[31:0]);
      check_val(rd_data[63:32]);
   endtask

   task automatic write_reg(input logic [4:0] sel, input logic [31:0] data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_data = data;
      @(posedge clk);
      if (sel != 5'd0) ref_mem[sel] = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic check_flags(input logic busy, input logic done, input string tag);
      expect_val({tag, "_busy"}, {31'd0, busy});
      expect_val({tag, "_done"}, {31'd0, done});
      #1;
      check_val({31'd0, clr_busy});
      check_val({31'd0, clr_done});
   endtask

   task automatic fill_and_start_clear();
      for (int i = 1; i < 32; i++) begin
         write_reg(5'(i), 32'(i) * 32'h01010101);
      end
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_sel  = '0;
      wr_data = '0;
      rd_sel  = '0;
      clr_req = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1: reset state
      check_flags(1'b0, 1'b0, "reset");
      for (int i = 0; i < 32; i++) read_pair(5'(i), 5'(31 - i), "reset");

      // 2: plain write, read next cycle, r0 on the other port
      write_reg(5'd5, 32'hDEADBEEF);
      read_pair(5'd5, 5'd0, "wr_r5");

      // 3: writes to r0 are discarded
      write_reg(5'd0, 32'hFFFFFFFF);
      read_pair(5'd0, 5'd0, "wr_r0");

      // 4: read of the register being written in the same cycle
      wr_en   = 1'b1;
      wr_sel  = 5'd7;
      wr_data = 32'h12345678;
      rd_sel  = {5'd5, 5'd7};
`ifdef BYPASS_EN
      expect_val("same_cycle_rd0_r7", 32'h12345678);
`else
      expect_val("same_cycle_rd0_r7", ref_mem[7]);
`endif
      expect_val("same_cycle_rd1_r5", ref_mem[5]);
      #1;
      check_val(rd_data[31:0]);
      check_val(rd_data[63:32]);
      @(posedge clk);
      ref_mem[7] = 32'h12345678;
      @(negedge clk);
      wr_en = 1'b0;
      read_pair(5'd7, 5'd7, "after_wr_r7");

      // 5: full bulk clear with a dropped write in the middle
      fill_and_start_clear();
      for (int c = 0; c < 31; c++) begin
         if (c >= 1) ref_mem[c] = 32'h0;
         if (c == 5) begin
            wr_en   = 1'b1;
            wr_sel  = 5'd3;
            wr_data = 32'hAAAA5555;
         end
         if (c == 6) wr_en = 1'b0;
         check_flags(1'b1, 1'b0, $sformatf("clear_c%0d", c));
         read_pair(5'(c), 5'(31 - c), $sformatf("clear_c%0d", c));
         tick();
      end
      wr_en = 1'b0;
      ref_mem[31] = 32'h0;
      check_flags(1'b0, 1'b1, "clear_end");
      tick();
      check_flags(1'b0, 1'b0, "clear_after");
      for (int i = 0; i < 32; i++) read_pair(5'(i), 5'(31 - i), "cleared");

      // 6: asynchronous reset in the middle of a clear
      fill_and_start_clear();
      for (int c = 0; c < 10; c++) tick();
      #1;
      rst = 1'b1;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      check_flags(1'b0, 1'b0, "rst_mid_clear");
      for (int i = 0; i < 32; i++) read_pair(5'(i), 5'(31 - i), "rst_mid_clear");
      @(negedge clk);
      rst = 1'b0;
      check_flags(1'b0, 1'b0, "post_rst");
      write_reg(5'd9, 32'hCAFEF00D);
      read_pair(5'd9, 5'd0, "post_rst_wr");

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
